// File: rtl/filter_buf_loader_pkg.sv
// Shared definitions for the filter buffer loader.
// Holds the default widths, the load FSM state encoding and small
// elaboration-time helpers used to size derived buses.
package filter_buf_loader_pkg;

  localparam int DEF_W_CHANNEL        = 6;
  localparam int DEF_W_FB_DATA        = 72;  // 9 x int8, one 3x3 kernel slice
  localparam int DEF_FB_WORDS_PER_CHN = 4;
  localparam int DEF_W_FB_ADDR        = 10;

  typedef enum logic [1:0] {
    FB_IDLE = 2'd0,
    FB_LOAD = 2'd1,
    FB_DONE = 2'd2
  } fb_state_t;

  // Width of the word-within-channel index; never narrower than one bit.
  function automatic int word_bits(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/filter_buf_loader_sram.sv
// fb_sram: simple dual-port RAM, one write port and one registered read port.
// A read and write to the same address in one cycle returns the old word.
// The array itself is never reset so it maps onto block RAM; only the
// read output register is reset.
// Ports: clk, rstn, we/waddr/wdata (write), re/raddr (read), rdata (registered).
module fb_sram #(
  parameter int W_DATA = 72,
  parameter int W_ADDR = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [W_ADDR-1:0] waddr,
  input  logic [W_DATA-1:0] wdata,
  input  logic              re,
  input  logic [W_ADDR-1:0] raddr,
  output logic [W_DATA-1:0] rdata
);

  logic [W_DATA-1:0] mem [2**W_ADDR];

  // Write port; no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; sampling mem before the write lands gives old data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/filter_buf_loader.sv
// filter_buf_loader: filter buffer manager for the CNN controller.
// On fb_load_req it loads q_channel*WORDS_PER_CHN weight words from a
// valid/ready stream into fb_sram, then pulses fb_load_done. During compute it
// serves registered reads addressed by (rd_chn, rd_word).
// Ports: clk, rstn | q_channel, fb_load_req, fb_load_done, o_busy |
//        s_wdata, s_wvalid, s_wready | rd_en, rd_chn, rd_word, rd_data, rd_valid | o_err
// Optional feature: define FB_ERR_DETECT_EN to enable the sticky o_err flag
// (request while busy, stream valid while idle, requested tile larger than depth).
module filter_buf_loader
  import filter_buf_loader_pkg::*;
#(
  parameter int W_CHANNEL     = DEF_W_CHANNEL,
  parameter int W_FB_DATA     = DEF_W_FB_DATA,
  parameter int WORDS_PER_CHN = DEF_FB_WORDS_PER_CHN,
  parameter int W_FB_ADDR     = DEF_W_FB_ADDR
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [W_CHANNEL-1:0]                 q_channel,
  input  logic                                 fb_load_req,
  output logic                                 fb_load_done,
  output logic                                 o_busy,
  input  logic [W_FB_DATA-1:0]                 s_wdata,
  input  logic                                 s_wvalid,
  output logic                                 s_wready,
  input  logic                                 rd_en,
  input  logic [W_CHANNEL-1:0]                 rd_chn,
  input  logic [word_bits(WORDS_PER_CHN)-1:0]  rd_word,
  output logic [W_FB_DATA-1:0]                 rd_data,
  output logic                                 rd_valid,
  output logic                                 o_err
);

  localparam int W_WORD = word_bits(WORDS_PER_CHN);
  // Product width wide enough to detect requests beyond the SRAM depth.
  localparam int W_TOT  = max_int(W_CHANNEL + W_WORD + 1, W_FB_ADDR + 2);
  localparam logic [W_TOT-1:0]   DEPTH_WIDE = W_TOT'(2**W_FB_ADDR);
  localparam logic [W_FB_ADDR:0] DEPTH_CNT  = (W_FB_ADDR+1)'(2**W_FB_ADDR);
  localparam logic [W_FB_ADDR:0] ONE_CNT    = (W_FB_ADDR+1)'(1);

  fb_state_t            state, next_state;
  logic [W_FB_ADDR:0]   total, wr_addr, total_req;
  logic [W_TOT-1:0]     total_full;
  logic                 start, beat, last_beat, over_depth;
  logic [W_FB_ADDR-1:0] rd_addr;

  assign total_full = W_TOT'(q_channel) * W_TOT'(WORDS_PER_CHN);
  assign over_depth = (total_full > DEPTH_WIDE);
  // Oversized tiles are clamped so the write address never wraps.
  assign total_req  = over_depth ? DEPTH_CNT : total_full[W_FB_ADDR:0];

  assign start      = (state == FB_IDLE) && fb_load_req;
  assign beat       = (state == FB_LOAD) && s_wvalid;
  assign last_beat  = (wr_addr == (total - ONE_CNT));

  assign s_wready     = (state == FB_LOAD);
  assign fb_load_done = (state == FB_DONE);
  assign o_busy       = (state != FB_IDLE);

  assign rd_addr = W_FB_ADDR'(rd_chn) * W_FB_ADDR'(WORDS_PER_CHN) + W_FB_ADDR'(rd_word);

  // Load FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= FB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Load FSM next-state logic; requests outside IDLE are ignored.
  always_comb begin
    next_state = state;
    case (state)
      FB_IDLE: begin
        if (fb_load_req) begin
          next_state = (total_req == '0) ? FB_DONE : FB_LOAD;
        end else begin
          next_state = FB_IDLE;
        end
      end
      FB_LOAD: begin
        if (beat && last_beat) begin
          next_state = FB_DONE;
        end else begin
          next_state = FB_LOAD;
        end
      end
      FB_DONE: next_state = FB_IDLE;
      default: next_state = FB_IDLE;
    endcase
  end

  // Latch tile size at request and advance the write address per accepted beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      total   <= '0;
      wr_addr <= '0;
    end else if (start) begin
      total   <= total_req;
      wr_addr <= '0;
    end else if (beat) begin
      total   <= total;
      wr_addr <= wr_addr + ONE_CNT;
    end else begin
      total   <= total;
      wr_addr <= wr_addr;
    end
  end

  // Read-valid tracks the strobe with the same one-cycle latency as the RAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  fb_sram #(
    .W_DATA (W_FB_DATA),
    .W_ADDR (W_FB_ADDR)
  ) u_sram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (beat),
    .waddr (wr_addr[W_FB_ADDR-1:0]),
    .wdata (s_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef FB_ERR_DETECT_EN
  logic err;

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if ((fb_load_req && (state != FB_IDLE)) ||
                 (s_wvalid && (state == FB_IDLE)) ||
                 (start && over_depth)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

  assign o_err = err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_filter_buf_loader.sv
// Directed self-checking bench for filter_buf_loader (default parameters).
module tb_filter_buf_loader;

  logic        clk;
  logic        rstn;
  logic [5:0]  q_channel;
  logic        fb_load_req;
  logic        fb_load_done;
  logic        o_busy;
  logic [71:0] s_wdata;
  logic        s_wvalid;
  logic        s_wready;
  logic        rd_en;
  logic [5:0]  rd_chn;
  logic [1:0]  rd_word;
  logic [71:0] rd_data;
  logic        rd_valid;
  logic        o_err;

  int tests;
  int fails;

  filter_buf_loader dut (
    .clk          (clk),
    .rstn         (rstn),
    .q_channel    (q_channel),
    .fb_load_req  (fb_load_req),
    .fb_load_done (fb_load_done),
    .o_busy       (o_busy),
    .s_wdata      (s_wdata),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .rd_en        (rd_en),
    .rd_chn       (rd_chn),
    .rd_word      (rd_word),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .o_err        (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] dw(input int base, input int i);
    return {8'(base), 56'h0, 8'(i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [5:0] chn, input logic [1:0] wrd);
    rd_en = 1'b1; rd_chn = chn; rd_word = wrd;
    tick();
    rd_en = 1'b0;
  endtask

  // Request a load of q channels and stream n back-to-back beats of dw(base, i).
  task automatic run_load(input logic [5:0] q, input int base, input int n);
    q_channel = q; fb_load_req = 1'b1;
    tick();
    fb_load_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_wvalid = 1'b1; s_wdata = dw(base, i);
      tick();
    end
    s_wvalid = 1'b0;
    chk("load_done", {71'h0, fb_load_done}, 72'h1);
    tick();
    chk("load_idle", {71'h0, o_busy}, 72'h0);
  endtask

  int wr_hi, done_seen, beats, cyc, done_cnt;
  logic busy_ok;
  logic exp_err;

  initial begin
    tests = 0; fails = 0;
    rstn = 1'b0; q_channel = 6'd0; fb_load_req = 1'b0; s_wdata = 72'h0;
    s_wvalid = 1'b0; rd_en = 1'b0; rd_chn = 6'd0; rd_word = 2'd0;
`ifdef FB_ERR_DETECT_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    tick(); tick();
    chk("rst_done",   {71'h0, fb_load_done}, 72'h0);
    chk("rst_busy",   {71'h0, o_busy}, 72'h0);
    chk("rst_wready", {71'h0, s_wready}, 72'h0);
    chk("rst_rvalid", {71'h0, rd_valid}, 72'h0);
    chk("rst_err",    {71'h0, o_err}, 72'h0);
    chk("rst_rdata",  rd_data, 72'h0);
    rstn = 1'b1;
    tick();

    // 1: three channels, 12 back-to-back beats.
    q_channel = 6'd3; fb_load_req = 1'b1;
    tick();
    fb_load_req = 1'b0;
    wr_hi = 0; done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      s_wvalid = 1'b1; s_wdata = dw(1, i);
      wr_hi += int'(s_wready);
      done_seen += int'(fb_load_done);
      tick();
    end
    s_wvalid = 1'b0;
    chk("t1_wready_cycles", 72'(wr_hi), 72'd12);
    chk("t1_no_early_done", 72'(done_seen), 72'd0);
    chk("t1_done",          {71'h0, fb_load_done}, 72'h1);
    chk("t1_wready_drop",   {71'h0, s_wready}, 72'h0);
    chk("t1_busy_in_done",  {71'h0, o_busy}, 72'h1);
    tick();
    chk("t1_done_1cyc",     {71'h0, fb_load_done}, 72'h0);
    chk("t1_idle",          {71'h0, o_busy}, 72'h0);
    rd(6'd2, 2'd1);
    chk("t1_rvalid",        {71'h0, rd_valid}, 72'h1);
    chk("t1_rd_c2w1",       rd_data, dw(1, 9));
    rd(6'd0, 2'd0);
    chk("t1_rd_c0w0",       rd_data, dw(1, 0));
    tick();
    chk("t1_rvalid_drop",   {71'h0, rd_valid}, 72'h0);

    // 2: gapped stream, two channels.
    q_channel = 6'd2; fb_load_req = 1'b1;
    tick();
    fb_load_req = 1'b0;
    beats = 0; cyc = 0; busy_ok = 1'b1; done_seen = 0;
    while (beats < 8 && cyc < 40) begin
      s_wvalid = (cyc % 2 == 0); s_wdata = dw(2, beats);
      busy_ok &= o_busy;
      done_seen += int'(fb_load_done);
      if (s_wvalid && s_wready) beats++;
      tick();
      cyc++;
    end
    s_wvalid = 1'b0;
    chk("t2_beats",   72'(beats), 72'd8);
    chk("t2_busy",    {71'h0, busy_ok}, 72'h1);
    chk("t2_no_early_done", 72'(done_seen), 72'd0);
    chk("t2_done",    {71'h0, fb_load_done}, 72'h1);
    tick();
    rd(6'd1, 2'd3);
    chk("t2_rd_c1w3", rd_data, dw(2, 7));

    // 3: zero channels -> straight to done, no beats.
    q_channel = 6'd0; fb_load_req = 1'b1;
    chk("t3_wready_req", {71'h0, s_wready}, 72'h0);
    tick();
    fb_load_req = 1'b0;
    chk("t3_done",   {71'h0, fb_load_done}, 72'h1);
    chk("t3_wready", {71'h0, s_wready}, 72'h0);
    tick();
    chk("t3_done_1cyc", {71'h0, fb_load_done}, 72'h0);
    chk("t3_wready_after", {71'h0, s_wready}, 72'h0);
    chk("err_clear_before_t4", {71'h0, o_err}, 72'h0);

    // 4: second request mid-load is ignored.
    q_channel = 6'd1; fb_load_req = 1'b1;
    tick();
    fb_load_req = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      s_wvalid = 1'b1; s_wdata = dw(4, i);
      fb_load_req = (i == 1);
      if (i == 1) q_channel = 6'd5;
      tick();
    end
    s_wvalid = 1'b0; fb_load_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      done_cnt += int'(fb_load_done);
      tick();
    end
    chk("t4_done_once", 72'(done_cnt), 72'd1);
    chk("t4_wready",    {71'h0, s_wready}, 72'h0);
    chk("t4_err",       {71'h0, o_err}, {71'h0, exp_err});
    rd(6'd0, 2'd3);
    chk("t4_rd_c0w3",   rd_data, dw(4, 3));

    // 5: reset after beat 5 of 12, then a clean reload.
    q_channel = 6'd3; fb_load_req = 1'b1;
    tick();
    fb_load_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_wvalid = 1'b1; s_wdata = dw(5, i);
      tick();
    end
    s_wvalid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("t5_abort_busy",   {71'h0, o_busy}, 72'h0);
    chk("t5_abort_wready", {71'h0, s_wready}, 72'h0);
    tick(); tick();
    rstn = 1'b1;
    done_seen = 0;
    for (int j = 0; j < 3; j++) begin
      done_seen += int'(fb_load_done);
      tick();
    end
    chk("t5_no_done", 72'(done_seen), 72'd0);
    chk("t5_err_cleared", {71'h0, o_err}, 72'h0);
    rd(6'd0, 2'd3);
    chk("t5_partial_kept", rd_data, dw(5, 3));
    run_load(6'd3, 6, 12);
    rd(6'd2, 2'd3);
    chk("t5_rd_c2w3", rd_data, dw(6, 11));

    // 6: same-cycle write/read of address 4 returns the previous word.
    q_channel = 6'd3; fb_load_req = 1'b1;
    tick();
    fb_load_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_wvalid = 1'b1; s_wdata = dw(7, i);
      rd_en = (i == 4); rd_chn = 6'd1; rd_word = 2'd0;
      if (i == 5) begin
        chk("t6_rvalid",  {71'h0, rd_valid}, 72'h1);
        chk("t6_old_data", rd_data, dw(6, 4));
      end
      tick();
    end
    s_wvalid = 1'b0; rd_en = 1'b0;
    tick();
    rd(6'd1, 2'd0);
    chk("t6_new_data", rd_data, dw(7, 4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
